// File: rtl/jk_pkg.sv
// Shared types for the JK bank arbiter: command encoding, FSM states, and the
// per-cell next-state rule.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } jk_state_e;

  // Command latched on accept; the target index lives beside it since its
  // width depends on the bank size.
  typedef struct packed {
    logic   id;
    jk_op_e op;
  } jk_cmd_t;

  function automatic logic jk_next(input logic cur, input logic j, input logic k);
    logic nxt;
    nxt = cur;
    unique case ({j, k})
      2'b00:   nxt = cur;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      default: nxt = ~cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// One clocked JK storage cell; holds its value unless enabled.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= jk_next(q, j, k);
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin front end for a bank of JK cells: accepts one command from two
// requesters, applies it to the addressed cell, then reports completion.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [IW-1:0] req0_idx,
  input  logic [1:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [IW-1:0] req1_idx,
  input  logic [1:0]    req1_op,
  output logic [N-1:0]  q,
  output logic          done,
  output logic          done_id,
  output logic          err,
  output logic          busy
);

  jk_state_e     state;
  jk_state_e     state_nx;
  logic          prio;
  jk_cmd_t       cmd_r;
  logic [IW-1:0] idx_r;
  logic          grant_vld;
  logic          grant_id;
  logic          idx_err;
  logic [N-1:0]  en;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and grant decision; only IDLE can grant.
  always_comb begin
    state_nx  = state;
    grant_vld = 1'b0;
    grant_id  = prio;
    unique case (state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_vld = 1'b1;
          grant_id  = (req0_valid && req1_valid) ? prio : req1_valid;
          state_nx  = ST_APPLY;
        end
      end
      ST_APPLY: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Ready is held low during reset even though the state may already be IDLE.
  assign req0_ready = rst_n && grant_vld && !grant_id;
  assign req1_ready = rst_n && grant_vld &&  grant_id;

  // Compare one bit wider so that N == 2**IW is representable.
  assign idx_err = ({1'b0, idx_r} >= (IW + 1)'(N));

  // Command latch, priority pointer and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      cmd_r   <= '{id: 1'b0, op: JK_HOLD};
      idx_r   <= '0;
      done    <= 1'b0;
      done_id <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (grant_vld) begin
        prio     <= ~grant_id;
        cmd_r.id <= grant_id;
        cmd_r.op <= jk_op_e'(grant_id ? req1_op : req0_op);
        idx_r    <= grant_id ? req1_idx : req0_idx;
      end
      done <= (state == ST_APPLY);
      err  <= (state == ST_APPLY) && idx_err;
      if (state == ST_APPLY) begin
        done_id <= cmd_r.id;
      end
      busy <= (state_nx != ST_IDLE);
    end
  end

  // One-hot enable into the bank; an out-of-range index touches nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    assign en[gi] = (state == ST_APPLY) && !idx_err && (idx_r == IW'(gi));

    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[gi]),
      .j     (cmd_r.op[1]),
      .k     (cmd_r.op[0]),
      .q     (q[gi])
    );
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: vector table, contention/reset/error sequences and
// a randomized run against a command-level model of the bank.
module tb_jk_bank_arbiter;
  import jk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v0, v1, rd0, rd1;
  logic [2:0] i0, i1;
  logic [1:0] o0, o1;
  logic [7:0] q;
  logic       done, did, err, busy;

  logic       w0, w1, wr0, wr1;
  logic [2:0] wi0, wi1;
  logic [1:0] wo0, wo1;
  logic [5:0] wq;
  logic       wdone, wdid, werr, wbusy;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  jk_bank_arbiter #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rd0), .req0_idx(i0), .req0_op(o0),
    .req1_valid(v1), .req1_ready(rd1), .req1_idx(i1), .req1_op(o1),
    .q(q), .done(done), .done_id(did), .err(err), .busy(busy)
  );

  jk_bank_arbiter #(.N(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w0), .req0_ready(wr0), .req0_idx(wi0), .req0_op(wo0),
    .req1_valid(w1), .req1_ready(wr1), .req1_idx(wi1), .req1_op(wo1),
    .q(wq), .done(wdone), .done_id(wdid), .err(werr), .busy(wbusy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; i0 = '0; i1 = '0; o0 = '0; o1 = '0;
    w0 = 1'b0; w1 = 1'b0; wi0 = '0; wi1 = '0; wo0 = '0; wo1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'({q, done, did, err, busy, rd0, rd1}), 32'h0);
    check("reset_state6", 32'({wq, wdone, wdid, werr, wbusy, wr0, wr1}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Single command on the 8-cell bank; returns the accept cycle or -1.
  task automatic issue(input bit r, input logic [2:0] idx, input jk_op_e op,
                       input logic [7:0] exp_q, output int acc);
    int w;
    w = 0;
    acc = -1;
    if (r) begin v1 = 1'b1; i1 = idx; o1 = op; end
    else   begin v0 = 1'b1; i0 = idx; o0 = op; end
    @(negedge clk);
    while (!(r ? rd1 : rd0) && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (w >= 10) begin
      check("accept_timeout", 32'(r ? rd1 : rd0), 32'd1);
      v0 = 1'b0; v1 = 1'b0;
      return;
    end
    check("ready_exclusive", 32'(r ? rd0 : rd1), 32'd0);
    check("busy_in_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    acc = cyc;
    if (r) v1 = 1'b0; else v0 = 1'b0;
    @(negedge clk);
    check("apply_cycle", 32'({busy, done, rd0, rd1}), 32'b1000);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_id", 32'(did), 32'(r));
    check("err_clear", 32'(err), 32'd0);
    check("q_after", 32'(q), 32'(exp_q));
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit         r;
    logic [2:0] idx;
    jk_op_e     op;
    logic [7:0] exp_q;
  } vec_t;

  typedef struct {
    logic [2:0] idx;
    jk_op_e     op;
    logic [5:0] exp_q;
    logic       exp_err;
  } vec6_t;

  initial begin : main
    vec_t       tbl[15];
    vec6_t      t6[4];
    int         acc, prev_acc, ng, nd, w;
    bit         g, r;
    bit         pv[2];
    logic [2:0] pidx[2];
    jk_op_e     pop[2];
    logic [7:0] mq;
    bit         mprio;

    tbl[0]  = '{1'b0, 3'd3, JK_SET,  8'h08};
    tbl[1]  = '{1'b1, 3'd3, JK_TGL,  8'h00};
    tbl[2]  = '{1'b1, 3'd3, JK_TGL,  8'h08};
    tbl[3]  = '{1'b0, 3'd0, JK_SET,  8'h09};
    tbl[4]  = '{1'b1, 3'd1, JK_SET,  8'h0B};
    tbl[5]  = '{1'b0, 3'd2, JK_SET,  8'h0F};
    tbl[6]  = '{1'b1, 3'd4, JK_SET,  8'h1F};
    tbl[7]  = '{1'b0, 3'd5, JK_SET,  8'h3F};
    tbl[8]  = '{1'b1, 3'd6, JK_SET,  8'h7F};
    tbl[9]  = '{1'b0, 3'd7, JK_SET,  8'hFF};
    tbl[10] = '{1'b0, 3'd2, JK_HOLD, 8'hFF};
    tbl[11] = '{1'b1, 3'd5, JK_RST,  8'hDF};
    tbl[12] = '{1'b0, 3'd0, JK_TGL,  8'hDE};
    tbl[13] = '{1'b1, 3'd7, JK_HOLD, 8'hDE};
    tbl[14] = '{1'b1, 3'd7, JK_RST,  8'h5E};

    t6[0] = '{3'd7, JK_SET, 6'h00, 1'b1};
    t6[1] = '{3'd5, JK_SET, 6'h20, 1'b0};
    t6[2] = '{3'd6, JK_TGL, 6'h20, 1'b1};
    t6[3] = '{3'd0, JK_TGL, 6'h21, 1'b0};

    // Vector table on the 8-cell bank.
    do_reset();
    prev_acc = 0;
    for (int k = 0; k < 15; k++) begin
      issue(tbl[k].r, tbl[k].idx, tbl[k].op, tbl[k].exp_q, acc);
      if (k == 2) check("b2b_spacing", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end

    // Continuous contention: grants and completions must alternate from 0.
    do_reset();
    v0 = 1'b1; i0 = 3'd0; o0 = JK_SET;
    v1 = 1'b1; i1 = 3'd1; o1 = JK_SET;
    ng = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("ready_while_busy", 32'(busy && (rd0 || rd1)), 32'd0);
      check("single_ready", 32'(rd0 && rd1), 32'd0);
      if (rd0 || rd1) begin
        check("grant_order", 32'(rd1), 32'(ng % 2));
        ng++;
      end
      if (done) begin
        check("done_alternates", 32'(did), 32'(nd % 2));
        nd++;
      end
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    check("contention_grants", 32'(ng >= 6), 32'd1);
    check("contention_q", 32'(q), 32'h03);

    // Reset during APPLY: command abandoned, prio cleared, ready gated.
    do_reset();
    issue(1'b0, 3'd4, JK_SET, 8'h10, acc);
    v0 = 1'b1; i0 = 3'd5; o0 = JK_SET;
    @(negedge clk);
    check("mid_accept", 32'(rd0), 32'd1);
    @(posedge clk); #1;
    v0 = 1'b0;
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1; i1 = 3'd1; o1 = JK_SET;
    @(negedge clk);
    check("apply_before_rst", 32'({rd0, rd1}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", 32'({done, busy}), 32'd0);
      check("rst_q_clear", 32'(q), 32'h00);
      check("rst_ready_gated", 32'({rd0, rd1}), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("prio_after_rst", 32'({rd0, rd1}), 32'b10);
    #1 v0 = 1'b0;
    #1 check("req1_first", 32'({rd0, rd1}), 32'b01);
    @(posedge clk); #1;
    v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_done", 32'({done, did, err}), 32'b110);
    check("post_rst_q", 32'(q), 32'h02);
    @(posedge clk); #1;

    // Out-of-range index on the 6-cell bank.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w0 = 1'b1; wi0 = t6[k].idx; wo0 = t6[k].op;
      w = 0;
      @(negedge clk);
      while (!wr0 && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("n6_accept", 32'({wr0, wr1}), 32'b10);
      @(posedge clk); #1;
      w0 = 1'b0;
      @(negedge clk);
      check("n6_apply", 32'({wbusy, wdone, werr}), 32'b100);
      @(negedge clk);
      check("n6_done", 32'({wdone, wdid}), 32'b10);
      check("n6_err", 32'(werr), 32'(t6[k].exp_err));
      check("n6_q", 32'(wq), 32'(t6[k].exp_q));
      @(posedge clk); #1;
    end

    // Randomized traffic against a command-level model of the bank.
    do_reset();
    mq = 8'h00;
    mprio = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pidx[0] = '0; pidx[1] = '0; pop[0] = JK_HOLD; pop[1] = JK_HOLD;
    for (int t = 0; t < 80; t++) begin
      if (!pv[0] && !pv[1]) begin
        r = 1'($urandom_range(0, 1));
        pv[r] = 1'b1; pidx[r] = 3'($urandom_range(0, 7)); pop[r] = jk_op_e'($urandom_range(0, 3));
      end
      v0 = pv[0]; i0 = pidx[0]; o0 = pop[0];
      v1 = pv[1]; i1 = pidx[1]; o1 = pop[1];
      @(negedge clk);
      g = (pv[0] && pv[1]) ? mprio : pv[1];
      check("rnd_grant", 32'({rd0, rd1}), g ? 32'b01 : 32'b10);
      check("rnd_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      case (pop[g])
        JK_RST:  mq[pidx[g]] = 1'b0;
        JK_SET:  mq[pidx[g]] = 1'b1;
        JK_TGL:  mq[pidx[g]] = ~mq[pidx[g]];
        default: ;
      endcase
      mprio = ~g;
      pv[g] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (!pv[k] && $urandom_range(0, 2) == 0) begin
          pv[k] = 1'b1; pidx[k] = 3'($urandom_range(0, 7)); pop[k] = jk_op_e'($urandom_range(0, 3));
        end
      end
      v0 = pv[0]; i0 = pidx[0]; o0 = pop[0];
      v1 = pv[1]; i1 = pidx[1]; o1 = pop[1];
      @(negedge clk);
      check("rnd_apply", 32'({busy, done, rd0, rd1}), 32'b1000);
      @(negedge clk);
      check("rnd_done", 32'({done, did, err}), 32'({1'b1, g, 1'b0}));
      check("rnd_q", 32'(q), 32'(mq));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete by t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
